axi_b_router: RTL

AXI_B_ROUTER -- requirements
Module: axi_b_router

---
 rtl/axi_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/axi_b_router.sv | 129 ++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: BRESP codes, default router geometry and the
// state encoding of the per-master output slot.
package axi_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int DEF_NUM_S    = 6;
  localparam int DEF_NUM_M    = 2;
  localparam int DEF_IDS_BITS = 8;
  localparam int DEF_ID_BITS  = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from a priority pointer that
// moves past the winner only when the caller reports the grant was used.
module rr_arbiter #(
  parameter int N = 6
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;

  // NOTE: every combinational output gets a default before the search loop so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    w_win = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        w_win    = PTR_W'(j);
      end
    end
  end

  // NOTE: reset is sampled on the clock edge, and state is updated with
  // non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/axi_b_router.sv
// AXI write-response router: slave B channels to master B channels by the
// master index in the upper BID bits, one registered slot per master.
module axi_b_router
  import axi_pkg::*;
#(
  parameter int NUM_S    = DEF_NUM_S,
  parameter int NUM_M    = DEF_NUM_M,
  parameter int IDS_BITS = DEF_IDS_BITS,
  parameter int ID_BITS  = DEF_ID_BITS
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_S-1:0]          s_bvalid,
  input  logic [NUM_S*IDS_BITS-1:0] s_bid,
  input  logic [NUM_S*2-1:0]        s_bresp,
  output logic [NUM_S-1:0]          s_bready,
  output logic [NUM_M-1:0]          m_bvalid,
  output logic [NUM_M*ID_BITS-1:0]  m_bid,
  output logic [NUM_M*2-1:0]        m_bresp,
  input  logic [NUM_M-1:0]          m_bready,
  output logic                      drop_o
);

  localparam int MIDX_W = IDS_BITS - ID_BITS;

  logic [MIDX_W-1:0]                 w_midx [NUM_S];
  logic [NUM_M-1:0][NUM_S-1:0]       w_req;
  logic [NUM_M-1:0][NUM_S-1:0]       w_grant;
  logic [NUM_S-1:0]                  w_drop_req;
  logic [NUM_M-1:0]                  w_accept;
  logic [NUM_M-1:0][ID_BITS-1:0]     w_nxt_bid;
  logic [NUM_M-1:0][1:0]             w_nxt_bresp;

  slot_state_e                       r_state [NUM_M];
  logic [NUM_M-1:0][ID_BITS-1:0]     r_bid;
  logic [NUM_M-1:0][1:0]             r_bresp;
  logic                              r_drop;

  for (genvar i = 0; i < NUM_S; i++) begin : g_midx
    assign w_midx[i] = s_bid[i*IDS_BITS+ID_BITS +: MIDX_W];
  end

  // Requests are decoded per target master, so one master's congestion never
  // gates s_bready of a slave aimed at another master.
  always_comb begin
    w_req      = '0;
    w_drop_req = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (s_bvalid[i]) begin
        if (int'(w_midx[i]) >= NUM_M) w_drop_req[i] = 1'b1;
        for (int m = 0; m < NUM_M; m++) begin
          if (int'(w_midx[i]) == m) w_req[m][i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      w_accept[m] = ARESETn && (|w_req[m]) &&
                    ((r_state[m] == SLOT_EMPTY) || m_bready[m]);
    end
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_arb
    rr_arbiter #(.N(NUM_S)) u_arb (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .req     (w_req[m]),
      .advance (w_accept[m]),
      .grant   (w_grant[m])
    );
  end

  // Payload of the granted slave; the default slave always answers DECERR.
  always_comb begin
    w_nxt_bid   = '0;
    w_nxt_bresp = '0;
    for (int m = 0; m < NUM_M; m++) begin
      for (int i = 0; i < NUM_S; i++) begin
        if (w_grant[m][i]) begin
          w_nxt_bid[m]   = s_bid[i*IDS_BITS +: ID_BITS];
          w_nxt_bresp[m] = (i == NUM_S - 1) ? BRESP_DECERR : s_bresp[i*2 +: 2];
        end
      end
    end
  end

  always_comb begin
    s_bready = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (w_drop_req[i]) s_bready[i] = 1'b1;
      for (int m = 0; m < NUM_M; m++) begin
        if (w_grant[m][i] && w_accept[m]) s_bready[i] = 1'b1;
      end
      if (!ARESETn) s_bready[i] = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int m = 0; m < NUM_M; m++) begin
        r_state[m] <= SLOT_EMPTY;
        r_bid[m]   <= '0;
        r_bresp[m] <= BRESP_OKAY;
      end
      r_drop <= 1'b0;
    end else begin
      for (int m = 0; m < NUM_M; m++) begin
        if (w_accept[m]) begin
          r_state[m] <= SLOT_FULL;
          r_bid[m]   <= w_nxt_bid[m];
          r_bresp[m] <= w_nxt_bresp[m];
        end else if (m_bready[m]) begin
          r_state[m] <= SLOT_EMPTY;
        end
      end
      r_drop <= |w_drop_req;
    end
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_out
    assign m_bvalid[m] = (r_state[m] == SLOT_FULL);
  end
  assign m_bid   = r_bid;
  assign m_bresp = r_bresp;
  assign drop_o  = r_drop;

endmodule
